// File: rtl/mem_stage.sv
// Memory stage: latches the execute bundle, runs loads/stores over a
// ready/ack data port and drives the registered MEM/WB bundle.
module mem_stage #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_in,
    input  logic        mwreg_in,
    input  logic        mm2reg_in,
    input  logic        mwmem_in,
    input  logic [4:0]  mrd_in,
    input  logic [31:0] mqb_in,
    input  logic [31:0] malu_in,
    output logic        stall,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack,
    output logic        wvalid,
    output logic        wwreg,
    output logic        wm2reg,
    output logic [4:0]  wrd,
    output logic [31:0] walu,
    output logic [31:0] wmdo,
    output logic        align_err,
    output logic        bus_err
);

    typedef struct packed {
        logic        valid;
        logic        wreg;
        logic        m2reg;
        logic        wmem;
        logic [4:0]  rd;
        logic [31:0] qb;
        logic [31:0] alu;
    } lat_t;

    typedef enum logic {S_RUN, S_WAIT} state_t;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    lat_t       lat;
    state_t     state;
    state_t     state_n;
    logic [7:0] cnt;
    logic [7:0] cnt_n;
    logic       memop;
    logic       aligned;
    logic       abort;

    assign memop   = lat.valid & (lat.m2reg | lat.wmem);
    assign aligned = (lat.alu[1:0] == 2'b00);
    assign abort   = (state == S_WAIT) & (cnt == CNT_LAST) & ~dmem_ack;

    assign dmem_req   = memop & aligned & ~abort;
    assign stall      = memop & aligned & ~dmem_ack & ~abort;
    assign dmem_we    = lat.wmem;
    assign dmem_addr  = lat.alu;
    assign dmem_wdata = lat.qb;

    // EXE/MEM latch: frozen while an access is outstanding
    always_ff @(posedge clk) begin
        if (rst) begin
            lat <= '0;
        end else if (!stall) begin
            lat <= {valid_in, mwreg_in, mm2reg_in, mwmem_in,
                    mrd_in, mqb_in, malu_in};
        end
    end

    // Access FSM state and wait counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_RUN;
            cnt   <= 8'd0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    // Next state: enter WAIT on an unacked request, leave on ack or abort
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        case (state)
            S_RUN: begin
                if (dmem_req && !dmem_ack) begin
                    state_n = S_WAIT;
                    cnt_n   = 8'd1;
                end
            end
            S_WAIT: begin
                if (dmem_ack || abort) begin
                    state_n = S_RUN;
                    cnt_n   = 8'd0;
                end else begin
                    cnt_n = cnt + 8'd1;
                end
            end
            default: begin
                state_n = S_RUN;
                cnt_n   = 8'd0;
            end
        endcase
    end

    // MEM/WB register: retire, squash or bubble, plus error pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            wvalid    <= 1'b0;
            wwreg     <= 1'b0;
            wm2reg    <= 1'b0;
            wrd       <= 5'd0;
            walu      <= 32'd0;
            wmdo      <= 32'd0;
            align_err <= 1'b0;
            bus_err   <= 1'b0;
        end else begin
            wvalid    <= 1'b0;
            wwreg     <= 1'b0;
            wm2reg    <= 1'b0;
            wrd       <= 5'd0;
            walu      <= 32'd0;
            wmdo      <= 32'd0;
            align_err <= 1'b0;
            bus_err   <= 1'b0;
            if (!stall) begin
                if (memop && !aligned) begin
                    align_err <= 1'b1;
                end else if (abort) begin
                    bus_err <= 1'b1;
                end else if (lat.valid) begin
                    wvalid <= 1'b1;
                    wwreg  <= lat.wreg;
                    wm2reg <= lat.m2reg;
                    wrd    <= lat.rd;
                    walu   <= lat.alu;
                    wmdo   <= lat.m2reg ? dmem_rdata : 32'd0;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: scoreboard of retiring bundles plus
// checks on handshake, stall, error pulses and reset.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_in;
    logic        mwreg_in;
    logic        mm2reg_in;
    logic        mwmem_in;
    logic [4:0]  mrd_in;
    logic [31:0] mqb_in;
    logic [31:0] malu_in;
    logic        stall;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata;
    logic        dmem_ack;
    logic        wvalid;
    logic        wwreg;
    logic        wm2reg;
    logic [4:0]  wrd;
    logic [31:0] walu;
    logic [31:0] wmdo;
    logic        align_err;
    logic        bus_err;

    typedef struct {
        logic        wreg;
        logic        m2r;
        logic [4:0]  rd;
        logic [31:0] alu;
        logic [31:0] mdo;
    } wb_t;

    wb_t q[$];
    int  npass = 0;
    int  ntot  = 0;

    mem_stage #(.TIMEOUT(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .valid_in   (valid_in),
        .mwreg_in   (mwreg_in),
        .mm2reg_in  (mm2reg_in),
        .mwmem_in   (mwmem_in),
        .mrd_in     (mrd_in),
        .mqb_in     (mqb_in),
        .malu_in    (malu_in),
        .stall      (stall),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_addr  (dmem_addr),
        .dmem_wdata (dmem_wdata),
        .dmem_rdata (dmem_rdata),
        .dmem_ack   (dmem_ack),
        .wvalid     (wvalid),
        .wwreg      (wwreg),
        .wm2reg     (wm2reg),
        .wrd        (wrd),
        .walu       (walu),
        .wmdo       (wmdo),
        .align_err  (align_err),
        .bus_err    (bus_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        ntot++;
        assert (obs === exp) npass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic drv(input logic v, input logic wr, input logic m2r,
                       input logic wm, input logic [4:0] rd,
                       input logic [31:0] qb, input logic [31:0] alu);
        valid_in  = v;
        mwreg_in  = wr;
        mm2reg_in = m2r;
        mwmem_in  = wm;
        mrd_in    = rd;
        mqb_in    = qb;
        malu_in   = alu;
    endtask

    task automatic bubble();
        drv(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
    endtask

    task automatic expect_wb(input logic wr, input logic m2r,
                             input logic [4:0] rd, input logic [31:0] alu,
                             input logic [31:0] mdo);
        wb_t e;
        e.wreg = wr;
        e.m2r  = m2r;
        e.rd   = rd;
        e.alu  = alu;
        e.mdo  = mdo;
        q.push_back(e);
    endtask

    // Advance one edge, then compare any retiring bundle to the scoreboard
    task automatic tick();
        wb_t e;
        @(posedge clk);
        #1;
        if (wvalid === 1'b1) begin
            chk("sb_nonempty", 32'(q.size() != 0), 32'd1);
            if (q.size() != 0) begin
                e = q.pop_front();
                chk("sb_wwreg", 32'(wwreg), 32'(e.wreg));
                chk("sb_wm2reg", 32'(wm2reg), 32'(e.m2r));
                chk("sb_wrd", 32'(wrd), 32'(e.rd));
                chk("sb_walu", walu, e.alu);
                chk("sb_wmdo", wmdo, e.mdo);
            end
        end
    endtask

    initial begin
        rst        = 1'b1;
        dmem_ack   = 1'b0;
        dmem_rdata = 32'd0;
        bubble();
        tick();
        tick();
        chk("rst_wvalid", 32'(wvalid), 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_req", 32'(dmem_req), 32'd0);
        chk("rst_walu", walu, 32'd0);
        chk("rst_errs", 32'({align_err, bus_err}), 32'd0);
        rst = 1'b0;
        tick();

        // ALU op
        drv(1'b1, 1'b1, 1'b0, 1'b0, 5'd5, 32'd0, 32'h1234);
        expect_wb(1'b1, 1'b0, 5'd5, 32'h1234, 32'd0);
        tick();
        bubble();
        chk("alu_stall", 32'(stall), 32'd0);
        chk("alu_req", 32'(dmem_req), 32'd0);
        tick();
        chk("alu_wvalid", 32'(wvalid), 32'd1);

        // Zero-wait load
        drv(1'b1, 1'b1, 1'b1, 1'b0, 5'd7, 32'd0, 32'h40);
        expect_wb(1'b1, 1'b1, 5'd7, 32'h40, 32'hDEADBEEF);
        tick();
        bubble();
        dmem_ack   = 1'b1;
        dmem_rdata = 32'hDEADBEEF;
        #1;
        chk("zw_req", 32'(dmem_req), 32'd1);
        chk("zw_we", 32'(dmem_we), 32'd0);
        chk("zw_addr", dmem_addr, 32'h40);
        chk("zw_stall", 32'(stall), 32'd0);
        tick();
        dmem_ack   = 1'b0;
        dmem_rdata = 32'd0;
        chk("zw_wvalid", 32'(wvalid), 32'd1);

        // Store with three wait cycles; upstream changes ignored
        drv(1'b1, 1'b0, 1'b0, 1'b1, 5'd3, 32'hCAFE0001, 32'h80);
        expect_wb(1'b0, 1'b0, 5'd3, 32'h80, 32'd0);
        tick();
        for (int i = 0; i < 3; i++) begin
            drv(1'b1, 1'b1, 1'b0, 1'b0, 5'(31 - i), 32'hFFFF, 32'hBAD0 + i);
            #1;
            chk("st_stall", 32'(stall), 32'd1);
            chk("st_addr", dmem_addr, 32'h80);
            chk("st_we", 32'(dmem_we), 32'd1);
            chk("st_wdata", dmem_wdata, 32'hCAFE0001);
            chk("st_wbubble", 32'(wvalid), 32'd0);
            tick();
        end
        drv(1'b1, 1'b1, 1'b0, 1'b0, 5'd9, 32'd0, 32'h999);
        expect_wb(1'b1, 1'b0, 5'd9, 32'h999, 32'd0);
        dmem_ack = 1'b1;
        #1;
        chk("st_ack_req", 32'(dmem_req), 32'd1);
        chk("st_ack_stall", 32'(stall), 32'd0);
        tick();
        dmem_ack = 1'b0;
        bubble();
        chk("st_retire", 32'(wvalid), 32'd1);
        tick();
        chk("st_next", 32'(wvalid), 32'd1);

        // Misaligned load is squashed without a request
        drv(1'b1, 1'b1, 1'b1, 1'b0, 5'd4, 32'd0, 32'h42);
        tick();
        drv(1'b1, 1'b1, 1'b0, 1'b0, 5'd10, 32'd0, 32'h55);
        expect_wb(1'b1, 1'b0, 5'd10, 32'h55, 32'd0);
        chk("mis_req", 32'(dmem_req), 32'd0);
        chk("mis_stall", 32'(stall), 32'd0);
        tick();
        bubble();
        chk("mis_aerr", 32'(align_err), 32'd1);
        chk("mis_wvalid", 32'(wvalid), 32'd0);
        chk("mis_next_stall", 32'(stall), 32'd0);
        tick();
        chk("mis_aerr_clr", 32'(align_err), 32'd0);
        chk("mis_next_wv", 32'(wvalid), 32'd1);

        // Timeout with ack held low, then a late ack
        drv(1'b1, 1'b1, 1'b1, 1'b0, 5'd6, 32'd0, 32'h100);
        tick();
        bubble();
        for (int i = 0; i < 3; i++) begin
            chk("to_stall", 32'(stall), 32'd1);
            chk("to_req", 32'(dmem_req), 32'd1);
            tick();
        end
        chk("to_stall_drop", 32'(stall), 32'd0);
        chk("to_req_drop", 32'(dmem_req), 32'd0);
        tick();
        chk("to_berr", 32'(bus_err), 32'd1);
        chk("to_wvalid", 32'(wvalid), 32'd0);
        dmem_ack = 1'b1;
        #1;
        chk("late_req", 32'(dmem_req), 32'd0);
        tick();
        dmem_ack = 1'b0;
        chk("late_berr_clr", 32'(bus_err), 32'd0);
        chk("late_wvalid", 32'(wvalid), 32'd0);
        chk("late_stall", 32'(stall), 32'd0);

        // Reset in the middle of WAIT
        drv(1'b1, 1'b1, 1'b1, 1'b0, 5'd8, 32'd0, 32'h200);
        tick();
        bubble();
        tick();
        chk("rw_stall", 32'(stall), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rw_req", 32'(dmem_req), 32'd0);
        chk("rw_stall0", 32'(stall), 32'd0);
        chk("rw_wvalid", 32'(wvalid), 32'd0);
        chk("rw_wdata", 32'({wwreg, wm2reg, wrd}), 32'd0);
        drv(1'b1, 1'b1, 1'b0, 1'b0, 5'd12, 32'd0, 32'hABC);
        expect_wb(1'b1, 1'b0, 5'd12, 32'hABC, 32'd0);
        tick();
        bubble();
        chk("rw_fresh_stall", 32'(stall), 32'd0);
        tick();
        chk("rw_fresh_wv", 32'(wvalid), 32'd1);
        tick();

        chk("sb_drained", 32'(q.size()), 32'd0);
        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Consumer side of the execute-stage output bundle: register-write, mem-to-reg and mem-write controls, destination register, store data and ALU result.
- Latches the bundle into an internal EXE/MEM register and performs loads/stores over a ready/ack data-memory port.
- Drives a registered MEM/WB bundle to writeback.
- Back-pressures the pipeline with a stall while a memory access is outstanding.

Parameters:
- TIMEOUT, 16, max cycles an access waits for dmem_ack before abort (legal range 2..255)

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous active-high reset
- valid_in  in  1  execute bundle holds a real instruction (0 = bubble)
- mwreg_in  in  1  instruction writes register file
- mm2reg_in  in  1  instruction is a load
- mwmem_in  in  1  instruction is a store
- mrd_in  in  5  destination register number
- mqb_in  in  32  store data
- malu_in  in  32  ALU result / effective address
- stall  out  1  upstream must hold its outputs; block ignores inputs this edge
- dmem_req  out  1  memory request
- dmem_we  out  1  1 = write, 0 = read
- dmem_addr  out  32  word-aligned byte address
- dmem_wdata  out  32  store data
- dmem_rdata  in  32  load data, valid with dmem_ack
- dmem_ack  in  1  memory completes current request this cycle
- wvalid  out  1  MEM/WB bundle valid
- wwreg  out  1  writeback enable
- wm2reg  out  1  select memory data at writeback
- wrd  out  5  destination register
- walu  out  32  ALU result
- wmdo  out  32  load data (0 for non-loads)
- align_err  out  1  one-cycle pulse: misaligned access squashed
- bus_err  out  1  one-cycle pulse: access timed out and squashed

Behaviour:
- Internal latch L {valid, wreg, m2reg, wmem, rd, qb, alu}.
- Latch rule: L loads the inputs on every edge where stall=0. It holds while stall=1.
- memop = L.valid & (L.m2reg | L.wmem).
- aligned = (L.alu[1:0] == 0).
- States: RUN, WAIT. Counter cnt, 8 bits.
- Request:
  - dmem_req = memop & aligned & ~abort, combinational, in both states.
  - dmem_addr = L.alu.
  - dmem_we = L.wmem.
  - dmem_wdata = L.qb.
  - Fields are stable for the whole request because L is frozen.
- abort = (state == WAIT) & (cnt == TIMEOUT-1) & ~dmem_ack.
- stall = memop & aligned & ~dmem_ack & ~abort.
- RUN state:
  - dmem_req & dmem_ack (zero-wait): the access completes and the instruction retires next edge.
  - dmem_req & ~dmem_ack: go to WAIT, cnt <= 1.
- WAIT state:
  - On ack: go to RUN, retire.
  - On abort: go to RUN, bus_err <= 1 for one cycle, instruction squashed.
  - Otherwise: cnt <= cnt+1.
- Retire (edge where L is valid and stall=0):
  - wvalid <= 1.
  - wwreg <= L.wreg.
  - wm2reg <= L.m2reg.
  - wrd <= L.rd.
  - walu <= L.alu.
  - wmdo <= dmem_rdata if L.m2reg, else 0.
- Squash (misaligned memop, or abort):
  - wvalid <= 0, wwreg <= 0; other W fields also 0.
  - align_err pulses for misaligned: no request is issued and stall stays 0.
- While stall=1 each edge writes a bubble into W (all W outputs 0).
- A bubble latch (L.valid=0) also writes all W outputs 0.
- Latency:
  - Non-memory instruction: input sampled at edge N, on W outputs after edge N+1.
  - Memory instruction with ack in cycle k after capture: on W outputs after edge N+1+k.
- Error flags: align_err and bus_err are registered pulses and are cleared the following cycle.
- Reset: L invalid, state RUN, cnt 0. Every registered output is 0: wvalid, wwreg, wm2reg, wrd, walu, wmdo, align_err, bus_err. With L invalid, stall and dmem_req are 0.
- Reset mid-WAIT: abandons the request. dmem_req drops the cycle after the reset edge and no retire occurs.
- A late dmem_ack arriving after an abort is ignored, because no request is outstanding.

Test Plan:
- ALU op: valid_in=1, wreg=1, rd=5, alu=0x1234 -> after 2 edges wvalid=1, wwreg=1, wrd=5, walu=0x1234, wmdo=0; stall never 1.
- Zero-wait load: m2reg=1, alu=0x40, rdata=0xDEADBEEF with ack in the same cycle as req -> stall=0; next edge wm2reg=1, wmdo=0xDEADBEEF.
- 3-wait store: wmem=1, alu=0x80, qb=0xCAFE0001, ack on 4th request cycle:
  - stall=1 for 3 cycles; dmem_addr, dmem_we and dmem_wdata stable throughout.
  - Upstream input changes are ignored while stalled.
  - W carries bubbles, then the store retires with wwreg=0, wvalid=1.
- Misaligned load alu=0x42 -> dmem_req never 1, align_err pulses once, W bubble, next instruction proceeds without stall.
- Timeout TIMEOUT=4, ack held low -> stall high for 3 cycles, stall and req drop in the 4th, bus_err pulses once, W bubble; an ack asserted one cycle later is ignored.
- Reset asserted during WAIT -> next cycle all outputs 0, dmem_req=0, state RUN; a fresh ALU op afterwards retires normally.
